// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: decode->execute pipeline register.
// Captures the decoded control word, operands, destination and PC and presents
// them registered to EX. Supports stall (freeze), flush (bubble) and a
// multi-cycle hold for MUL/DIV/MOD that back-pressures decode via multi_busy.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall_in, flush     freeze request / squash request
//   id_*                decode-side control word, operands, PC, registers
//   ex_*                registered copies of id_* (ex_wb_en gated in hold)
//   multi_busy          EX occupied by a multi-cycle op; decode must hold
module id_ex_stage_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned EXE_CMD_W  = 4,
  parameter int unsigned MULTI_LAT  = 3,
  parameter logic [EXE_CMD_W-1:0] OP_MUL = EXE_CMD_W'(4'hB),
  parameter logic [EXE_CMD_W-1:0] OP_DIV = EXE_CMD_W'(4'hC),
  parameter logic [EXE_CMD_W-1:0] OP_MOD = EXE_CMD_W'(4'hD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_in,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  id_branchEn,
  input  logic [EXE_CMD_W-1:0]  id_exe_cmd,
  input  logic [1:0]            id_branch_cmd,
  input  logic                  id_is_imm,
  input  logic                  id_st_or_bne,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  input  logic                  id_mem_w_en,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_val1,
  input  logic [DATA_W-1:0]     id_val2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  output logic                  ex_valid,
  output logic                  ex_branchEn,
  output logic [EXE_CMD_W-1:0]  ex_exe_cmd,
  output logic [1:0]            ex_branch_cmd,
  output logic                  ex_is_imm,
  output logic                  ex_st_or_bne,
  output logic                  ex_wb_en,
  output logic                  ex_mem_r_en,
  output logic                  ex_mem_w_en,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [DATA_W-1:0]     ex_val1,
  output logic [DATA_W-1:0]     ex_val2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic [REG_ADDR_W-1:0] ex_src1,
  output logic [REG_ADDR_W-1:0] ex_src2,
  output logic                  multi_busy
);

  // Counter must be at least one bit wide even when holds are disabled.
  localparam int unsigned CNT_W = (MULTI_LAT > 0) ? $clog2(MULTI_LAT + 1) : 1;

  typedef struct packed {
    logic                 valid;
    logic                 branch_en;
    logic [EXE_CMD_W-1:0] exe_cmd;
    logic [1:0]           branch_cmd;
    logic                 is_imm;
    logic                 st_or_bne;
    logic                 wb_en;
    logic                 mem_r_en;
    logic                 mem_w_en;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     val1;
    logic [DATA_W-1:0]     val2;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
  } data_t;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d, id_ctrl;
  data_t            data_q, data_d, id_data;
  logic             is_multi;

  // Pack decode-side fields.
  always_comb begin
    id_ctrl = '{valid: id_valid, branch_en: id_branchEn, exe_cmd: id_exe_cmd,
                branch_cmd: id_branch_cmd, is_imm: id_is_imm,
                st_or_bne: id_st_or_bne, wb_en: id_wb_en,
                mem_r_en: id_mem_r_en, mem_w_en: id_mem_w_en};
    id_data = '{pc: id_pc, val1: id_val1, val2: id_val2, imm: id_imm,
                dest: id_dest, src1: id_src1, src2: id_src2};
    is_multi = (id_exe_cmd == OP_MUL) || (id_exe_cmd == OP_DIV) ||
               (id_exe_cmd == OP_MOD);
  end

  // Next-state: flush > hold > stall > load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      ctrl_d  = '0;
      data_d  = '0;
    end else begin
      case (state_q)
        HOLD: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
        default: begin
          if (!stall_in) begin
            data_d = id_data;
            // An invalid slot carries no control, whatever decode presents.
            ctrl_d = id_valid ? id_ctrl : '0;
            if (id_valid && is_multi && (MULTI_LAT > 0)) begin
              state_d = HOLD;
              cnt_d   = CNT_W'(MULTI_LAT);
            end
          end
        end
      endcase
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign multi_busy = (state_q == HOLD);

  // Register write allowed only in the final residency cycle of a held op.
  assign ex_wb_en      = ctrl_q.wb_en & ~multi_busy;
  assign ex_valid      = ctrl_q.valid;
  assign ex_branchEn   = ctrl_q.branch_en;
  assign ex_exe_cmd    = ctrl_q.exe_cmd;
  assign ex_branch_cmd = ctrl_q.branch_cmd;
  assign ex_is_imm     = ctrl_q.is_imm;
  assign ex_st_or_bne  = ctrl_q.st_or_bne;
  assign ex_mem_r_en   = ctrl_q.mem_r_en;
  assign ex_mem_w_en   = ctrl_q.mem_w_en;
  assign ex_pc         = data_q.pc;
  assign ex_val1       = data_q.val1;
  assign ex_val2       = data_q.val2;
  assign ex_imm        = data_q.imm;
  assign ex_dest       = data_q.dest;
  assign ex_src1       = data_q.src1;
  assign ex_src2       = data_q.src2;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed self-checking bench for id_ex_stage_reg.
module tb_id_ex_stage_reg;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_MUL = 4'hB;
  localparam logic [3:0] OP_DIV = 4'hC;
  localparam logic [3:0] OP_MOD = 4'hD;

  logic        clk = 1'b0;
  logic        rst, stall_in, flush;
  logic        id_valid, id_branchEn, id_is_imm, id_st_or_bne;
  logic        id_wb_en, id_mem_r_en, id_mem_w_en;
  logic [3:0]  id_exe_cmd;
  logic [1:0]  id_branch_cmd;
  logic [31:0] id_pc, id_val1, id_val2, id_imm;
  logic [3:0]  id_dest, id_src1, id_src2;
  logic        ex_valid, ex_branchEn, ex_is_imm, ex_st_or_bne;
  logic        ex_wb_en, ex_mem_r_en, ex_mem_w_en;
  logic [3:0]  ex_exe_cmd;
  logic [1:0]  ex_branch_cmd;
  logic [31:0] ex_pc, ex_val1, ex_val2, ex_imm;
  logic [3:0]  ex_dest, ex_src1, ex_src2;
  logic        multi_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.MULTI_LAT(3)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
    .id_valid(id_valid), .id_branchEn(id_branchEn), .id_exe_cmd(id_exe_cmd),
    .id_branch_cmd(id_branch_cmd), .id_is_imm(id_is_imm),
    .id_st_or_bne(id_st_or_bne), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_pc(id_pc),
    .id_val1(id_val1), .id_val2(id_val2), .id_imm(id_imm), .id_dest(id_dest),
    .id_src1(id_src1), .id_src2(id_src2),
    .ex_valid(ex_valid), .ex_branchEn(ex_branchEn), .ex_exe_cmd(ex_exe_cmd),
    .ex_branch_cmd(ex_branch_cmd), .ex_is_imm(ex_is_imm),
    .ex_st_or_bne(ex_st_or_bne), .ex_wb_en(ex_wb_en),
    .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en), .ex_pc(ex_pc),
    .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_imm(ex_imm), .ex_dest(ex_dest),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .multi_busy(multi_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [3:0] cmd,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] d, input logic wb,
                           input logic mr, input logic mw);
    id_valid = v; id_exe_cmd = cmd; id_val1 = a; id_val2 = b; id_dest = d;
    id_wb_en = wb; id_mem_r_en = mr; id_mem_w_en = mw;
    id_branchEn = 1'b0; id_branch_cmd = 2'b00; id_is_imm = 1'b0;
    id_st_or_bne = 1'b0; id_pc = 32'h100 + a; id_imm = 32'hFFFF_FFF0;
    id_src1 = 4'd1; id_src2 = 4'd2;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, 64'(ex_valid), 64'd0);
    chk({tag, ".wb"},    64'(ex_wb_en), 64'd0);
    chk({tag, ".cmd"},   64'(ex_exe_cmd), 64'd0);
    chk({tag, ".busy"},  64'(multi_busy), 64'd0);
  endtask

  initial begin
    // Reset with random decode inputs.
    rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
    set_instr(1'b1, 4'($urandom), $urandom, $urandom, 4'($urandom), 1'b1, 1'b1, 1'b1);
    id_branchEn = 1'b1; id_branch_cmd = 2'b11; id_is_imm = 1'b1; id_st_or_bne = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_bubble("rst");
      chk("rst.val1", 64'(ex_val1), 64'd0);
      chk("rst.pc", 64'(ex_pc), 64'd0);
      chk("rst.mw", 64'(ex_mem_w_en), 64'd0);
      chk("rst.br", 64'(ex_branchEn), 64'd0);
    end
    rst = 1'b0;

    // Plain ADD load, one-cycle latency.
    set_instr(1'b1, OP_ADD, 32'd5, 32'd7, 4'd3, 1'b1, 1'b0, 1'b0);
    step();
    chk("add.val1", 64'(ex_val1), 64'd5);
    chk("add.val2", 64'(ex_val2), 64'd7);
    chk("add.dest", 64'(ex_dest), 64'd3);
    chk("add.wb", 64'(ex_wb_en), 64'd1);
    chk("add.valid", 64'(ex_valid), 64'd1);
    chk("add.cmd", 64'(ex_exe_cmd), 64'(OP_ADD));
    chk("add.pc", 64'(ex_pc), 64'h105);
    chk("add.src2", 64'(ex_src2), 64'd2);
    chk("add.busy", 64'(multi_busy), 64'd0);

    // Stall for three cycles: ex_* retained despite new inputs.
    stall_in = 1'b1;
    set_instr(1'b1, OP_MUL, 32'd99, 32'd98, 4'd9, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.val1", 64'(ex_val1), 64'd5);
      chk("stall.dest", 64'(ex_dest), 64'd3);
      chk("stall.wb", 64'(ex_wb_en), 64'd1);
      chk("stall.busy", 64'(multi_busy), 64'd0);
    end
    // Stall and flush together: flush wins.
    flush = 1'b1;
    step();
    chk_bubble("stflush");
    chk("stflush.val1", 64'(ex_val1), 64'd0);
    flush = 1'b0; stall_in = 1'b0;

    // MUL: three hold cycles then final residency cycle.
    set_instr(1'b1, OP_MUL, 32'd9, 32'd4, 4'd4, 1'b1, 1'b0, 1'b0);
    step();
    set_instr(1'b1, OP_ADD, 32'd1, 32'd2, 4'd6, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      chk("mul.busy", 64'(multi_busy), 64'd1);
      chk("mul.wb", 64'(ex_wb_en), 64'd0);
      chk("mul.val1", 64'(ex_val1), 64'd9);
      chk("mul.cmd", 64'(ex_exe_cmd), 64'(OP_MUL));
      step();
    end
    chk("mul.last.busy", 64'(multi_busy), 64'd0);
    chk("mul.last.wb", 64'(ex_wb_en), 64'd1);
    chk("mul.last.val1", 64'(ex_val1), 64'd9);
    chk("mul.last.dest", 64'(ex_dest), 64'd4);
    step();
    chk("postmul.val1", 64'(ex_val1), 64'd1);
    chk("postmul.cmd", 64'(ex_exe_cmd), 64'(OP_ADD));
    chk("postmul.busy", 64'(multi_busy), 64'd0);

    // DIV flushed mid-hold (cnt==2), then a normal load.
    set_instr(1'b1, OP_DIV, 32'd40, 32'd5, 4'd7, 1'b1, 1'b0, 1'b0);
    step();
    set_instr(1'b1, OP_ADD, 32'd11, 32'd12, 4'd8, 1'b1, 1'b0, 1'b0);
    chk("div.busy1", 64'(multi_busy), 64'd1);
    step();
    chk("div.busy2", 64'(multi_busy), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_bubble("divflush");
    step();
    chk("afterflush.val1", 64'(ex_val1), 64'd11);
    chk("afterflush.valid", 64'(ex_valid), 64'd1);
    chk("afterflush.wb", 64'(ex_wb_en), 64'd1);
    chk("afterflush.busy", 64'(multi_busy), 64'd0);

    // Modulo op also enters hold.
    set_instr(1'b1, OP_MOD, 32'd13, 32'd3, 4'd5, 1'b1, 1'b0, 1'b0);
    step();
    chk("mod.busy", 64'(multi_busy), 64'd1);
    chk("mod.wb", 64'(ex_wb_en), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_bubble("modflush");

    // Invalid slot: control zeroed, data loaded, no hold even for MUL code.
    set_instr(1'b0, OP_MUL, 32'h77, 32'h66, 4'd2, 1'b1, 1'b1, 1'b1);
    step();
    chk("inv.wb", 64'(ex_wb_en), 64'd0);
    chk("inv.mw", 64'(ex_mem_w_en), 64'd0);
    chk("inv.mr", 64'(ex_mem_r_en), 64'd0);
    chk("inv.valid", 64'(ex_valid), 64'd0);
    chk("inv.cmd", 64'(ex_exe_cmd), 64'd0);
    chk("inv.busy", 64'(multi_busy), 64'd0);
    chk("inv.val1", 64'(ex_val1), 64'h77);
    set_instr(1'b1, OP_ADD, 32'd3, 32'd4, 4'd1, 1'b0, 1'b1, 1'b0);
    step();
    chk("inv.next.val1", 64'(ex_val1), 64'd3);
    chk("inv.next.mr", 64'(ex_mem_r_en), 64'd1);
    chk("inv.next.busy", 64'(multi_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
